// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM state encoding and bench opcodes for the SRAM responder
package sram_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR_WAIT  = 2'd3
  } state_t;
  localparam int LD = 10;
  localparam int ST = 11;
endpackage

// File: rtl/sram_responder_if.sv
// sram_responder_if: SRAM address and active-low control pins; master drives, slave (responder) samples
interface sram_responder_if;
  import sram_pkg::*;
  logic [SRAM_ADDR_W-1:0] SRAM_ADDRESS;
  logic SRAM_UB_N;
  logic SRAM_LB_N;
  logic SRAM_WE_N;
  logic SRAM_CE_N;
  logic SRAM_OE_N;
  modport master (output SRAM_ADDRESS, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
  modport slave (input SRAM_ADDRESS, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N);
endinterface

// File: rtl/sram_byte_ram.sv
// sram_byte_ram: 2**DEPTH_LOG2 x 16 single-port RAM with per-byte write enables and registered read
// ports: clk; we/be/wdata write at addr; re loads rdata from addr
module sram_byte_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);
  logic [15:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[addr][7:0] <= wdata[7:0];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for a 256K x 16 async SRAM with access latency, byte lanes, counters and error pulses
// ports: clk/rst (sync, active high); sram = control pins (slave); SRAM_DATA = shared bus;
//        rd_count/wr_count saturating; err_oob/err_short one-cycle pulses; busy = not IDLE
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2,
  parameter int WRITE_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_responder_if.slave        sram,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DATA,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count,
  output logic                   err_oob,
  output logic                   err_short,
  output logic                   busy
);
  state_t state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [15:0] wdata_q, wdata_d, rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [1:0] wlanes_q, wlanes_d;
  logic err_oob_q, err_oob_d, err_short_q, err_short_d;
  logic sel, addr_chg, oob, commit, wr_ok, rd_load, drive;
  logic [1:0] lanes;
  logic [15:0] rdata, dout;
  assign sel = !sram.SRAM_CE_N;
  assign addr_chg = sram.SRAM_ADDRESS != addr_q;
  assign oob = |addr_q[SRAM_ADDR_W-1:DEPTH_LOG2];
  assign lanes = {!sram.SRAM_UB_N, !sram.SRAM_LB_N};
  assign commit = state_q == WR_WAIT && (sram.SRAM_WE_N || !sel || addr_chg);
  // rst gating drops a write whose commit edge coincides with reset
  assign wr_ok = commit && wcnt_q >= 3'(WRITE_LAT) && !oob && !rst;
  assign rd_load = state_q == RD_WAIT && sel && sram.SRAM_WE_N && !sram.SRAM_OE_N && !addr_chg && rcnt_q == 3'(READ_LAT);
  // release in the same cycle any exit condition appears, before the FSM leaves RD_DRIVE
  assign drive = state_q == RD_DRIVE && sel && !sram.SRAM_OE_N && sram.SRAM_WE_N && !addr_chg;
  assign dout = oob ? 16'h0000 : rdata;
  assign SRAM_DATA[15:8] = drive && lanes[1] ? dout[15:8] : 8'hzz;
  assign SRAM_DATA[7:0] = drive && lanes[0] ? dout[7:0] : 8'hzz;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rcnt_d = rcnt_q;
    wcnt_d = wcnt_q;
    wdata_d = wdata_q;
    wlanes_d = wlanes_q;
    rd_count_d = rd_count_q + 16'(rd_load && rd_count_q != 16'hFFFF);
    wr_count_d = wr_count_q + 16'(wr_ok && wr_count_q != 16'hFFFF);
    err_oob_d = (rd_load || commit) && oob;
    err_short_d = commit && wcnt_q < 3'(WRITE_LAT);
    if (sel && !sram.SRAM_WE_N && (state_q != WR_WAIT || addr_chg)) begin
      state_d = WR_WAIT;
      addr_d = sram.SRAM_ADDRESS;
      wcnt_d = 3'd1;
      wdata_d = SRAM_DATA;
      wlanes_d = lanes;
    end else if (state_q == WR_WAIT) begin
      // sampling continues until the commit edge, so wdata_q holds the last WE_N-low cycle
      state_d = commit ? IDLE : WR_WAIT;
      wcnt_d = wcnt_q == 3'd7 ? wcnt_q : wcnt_q + 3'd1;
      wdata_d = SRAM_DATA;
      wlanes_d = lanes;
    end else if (!sel || sram.SRAM_OE_N) begin
      state_d = IDLE;
    end else if (state_q == IDLE || addr_chg) begin
      state_d = RD_WAIT;
      addr_d = sram.SRAM_ADDRESS;
      rcnt_d = 3'd1;
    end else if (state_q == RD_WAIT) begin
      state_d = rcnt_q == 3'(READ_LAT) ? RD_DRIVE : RD_WAIT;
      rcnt_d = rcnt_q + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rcnt_q <= '0;
      wcnt_q <= '0;
      wdata_q <= '0;
      wlanes_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_oob_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
      wdata_q <= wdata_d;
      wlanes_q <= wlanes_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_oob_q <= err_oob_d;
      err_short_q <= err_short_d;
    end
  end
  sram_byte_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .re    (rd_load),
    .be    (wlanes_q),
    .addr  (addr_q[DEPTH_LOG2-1:0]),
    .wdata (wdata_q),
    .rdata (rdata)
  );
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign err_oob = err_oob_q;
  assign err_short = err_short_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed and randomized checks of sram_responder against a word-array reference model
module tb_sram_responder;
  import sram_pkg::*;
  localparam int DEPTH_LOG2 = 10;
  localparam int READ_LAT = 2;
  localparam int WRITE_LAT = 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv = 1'b0;
  logic [15:0] wdat = '0;
  tri1 [15:0] sram_data;
  logic [15:0] rd_count, wr_count;
  logic err_oob, err_short, busy;
  int n_cmp = 0;
  int n_bad = 0;
  int m_rd = 0;
  int m_wr = 0;
  logic [15:0] mem_m [DEPTH];
  sram_responder_if s();
  assign sram_data = drv ? wdat : 16'hzzzz;
  sram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sram      (s),
    .SRAM_DATA (sram_data),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .err_oob   (err_oob),
    .err_short (err_short),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_status(input string tag, input logic e_oob, input logic e_short);
    chk({tag, ":rd_count"}, rd_count, 16'(m_rd));
    chk({tag, ":wr_count"}, wr_count, 16'(m_wr));
    chk({tag, ":err_oob"}, {15'd0, err_oob}, {15'd0, e_oob});
    chk({tag, ":err_short"}, {15'd0, err_short}, {15'd0, e_short});
  endtask
  // Bus as seen through the pulled-up net: disabled lanes float high, out-of-range words read zero.
  function automatic logic [15:0] mdl_bus(input logic [17:0] a, input logic ub_n, input logic lb_n);
    logic [15:0] v;
    v = (a < 18'(DEPTH)) ? mem_m[a[DEPTH_LOG2-1:0]] : 16'h0000;
    return {ub_n ? 8'hFF : v[15:8], lb_n ? 8'hFF : v[7:0]};
  endfunction
  task automatic rd(input string tag, input logic [17:0] a, input logic ub_n, input logic lb_n);
    logic [15:0] exp;
    exp = mdl_bus(a, ub_n, lb_n);
    s.SRAM_ADDRESS = a;
    s.SRAM_UB_N = ub_n;
    s.SRAM_LB_N = lb_n;
    s.SRAM_WE_N = 1'b1;
    s.SRAM_CE_N = 1'b0;
    s.SRAM_OE_N = 1'b0;
    for (int i = 0; i < READ_LAT; i++) begin
      tick();
      @(negedge clk);
      chk({tag, ":latency"}, sram_data, 16'hFFFF);
    end
    tick();
    @(negedge clk);
    if (m_rd != 65535) m_rd++;
    chk({tag, ":data"}, sram_data, exp);
    chk_status(tag, a >= 18'(DEPTH), 1'b0);
    s.SRAM_OE_N = 1'b1;
    #1;
    chk({tag, ":release"}, sram_data, 16'hFFFF);
    tick();
    s.SRAM_CE_N = 1'b1;
    @(negedge clk);
    chk({tag, ":idle"}, {15'd0, busy, err_oob}, 16'd0);
  endtask
  task automatic wr(input string tag, input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n, input int nlow);
    s.SRAM_ADDRESS = a;
    s.SRAM_UB_N = ub_n;
    s.SRAM_LB_N = lb_n;
    s.SRAM_OE_N = 1'b1;
    s.SRAM_CE_N = 1'b0;
    s.SRAM_WE_N = 1'b0;
    drv = 1'b1;
    for (int i = 0; i < nlow; i++) begin
      wdat = (i == nlow - 1) ? d : 16'($urandom);
      tick();
    end
    s.SRAM_WE_N = 1'b1;
    drv = 1'b0;
    @(negedge clk);
    chk({tag, ":busy"}, {15'd0, busy}, 16'd1);
    tick();
    if (nlow >= WRITE_LAT && a < 18'(DEPTH)) begin
      if (!ub_n) mem_m[a[DEPTH_LOG2-1:0]][15:8] = d[15:8];
      if (!lb_n) mem_m[a[DEPTH_LOG2-1:0]][7:0] = d[7:0];
      if (m_wr != 65535) m_wr++;
    end
    @(negedge clk);
    chk_status(tag, a >= 18'(DEPTH), nlow < WRITE_LAT);
    s.SRAM_CE_N = 1'b1;
    tick();
    @(negedge clk);
    chk({tag, ":pulse_end"}, {14'd0, err_oob, err_short}, 16'd0);
  endtask
  initial begin
    logic [17:0] ra;
    int op;
    s.SRAM_ADDRESS = '0;
    s.SRAM_UB_N = 1'b0;
    s.SRAM_LB_N = 1'b0;
    s.SRAM_WE_N = 1'b1;
    s.SRAM_CE_N = 1'b1;
    s.SRAM_OE_N = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wr("seed", 18'h00005, 16'hC0DE, 1'b0, 1'b0, 2);
    s.SRAM_ADDRESS = 18'h00005;
    s.SRAM_CE_N = 1'b0;
    s.SRAM_OE_N = 1'b0;
    rst = 1'b1;
    tick();
    m_rd = 0;
    m_wr = 0;
    @(negedge clk);
    chk("reset:bus", sram_data, 16'hFFFF);
    chk("reset:busy", {15'd0, busy}, 16'd0);
    chk_status("reset", 1'b0, 1'b0);
    rst = 1'b0;
    rd("reset_read", 18'h00005, 1'b0, 1'b0);
    wr("beef", 18'h00010, 16'hBEEF, 1'b0, 1'b0, 4);
    rd("beef", 18'h00010, 1'b0, 1'b0);
    wr("lo_lane", 18'h00010, 16'h1234, 1'b1, 1'b0, 2);
    rd("lo_lane", 18'h00010, 1'b0, 1'b0);
    rd("hi_only", 18'h00010, 1'b0, 1'b1);
    rd("lo_only", 18'h00010, 1'b1, 1'b0);
    wr("short", 18'h00010, 16'hAAAA, 1'b0, 1'b0, 1);
    rd("short", 18'h00010, 1'b0, 1'b0);
    wr("alias", 18'h00000, 16'h0F0F, 1'b0, 1'b0, 2);
    rd("oob", 18'h00400, 1'b0, 1'b0);
    wr("oob", 18'h00400, 16'h5555, 1'b0, 1'b0, 3);
    rd("alias", 18'h00000, 1'b0, 1'b0);
    wr("a1", 18'h00001, 16'h1111, 1'b0, 1'b0, 2);
    wr("a2", 18'h00002, 16'h2222, 1'b0, 1'b0, 2);
    s.SRAM_ADDRESS = 18'h00001;
    s.SRAM_UB_N = 1'b0;
    s.SRAM_LB_N = 1'b0;
    s.SRAM_WE_N = 1'b1;
    s.SRAM_CE_N = 1'b0;
    s.SRAM_OE_N = 1'b0;
    tick();
    s.SRAM_ADDRESS = 18'h00002;
    for (int i = 0; i < READ_LAT; i++) begin
      tick();
      @(negedge clk);
      chk("restart:latency", sram_data, 16'hFFFF);
    end
    tick();
    @(negedge clk);
    m_rd++;
    chk("restart:data", sram_data, mdl_bus(18'h00002, 1'b0, 1'b0));
    chk_status("restart", 1'b0, 1'b0);
    s.SRAM_OE_N = 1'b1;
    tick();
    s.SRAM_CE_N = 1'b1;
    wr("a3", 18'h00003, 16'h0303, 1'b0, 1'b0, 2);
    s.SRAM_ADDRESS = 18'h00003;
    s.SRAM_OE_N = 1'b1;
    s.SRAM_CE_N = 1'b0;
    s.SRAM_WE_N = 1'b0;
    drv = 1'b1;
    wdat = 16'h3333;
    repeat (3) tick();
    rst = 1'b1;
    s.SRAM_WE_N = 1'b1;
    drv = 1'b0;
    tick();
    rst = 1'b0;
    s.SRAM_CE_N = 1'b1;
    m_rd = 0;
    m_wr = 0;
    @(negedge clk);
    chk("rst_wr:busy", {15'd0, busy}, 16'd0);
    chk_status("rst_wr", 1'b0, 1'b0);
    rd("rst_wr", 18'h00003, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) wr("fill", 18'h00020 + 18'(i), 16'($urandom), 1'b0, 1'b0, WRITE_LAT);
    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(4) == 0 ? 18'h00420 : 18'h00020) + 18'($urandom_range(7));
      op = $urandom_range(1) == 1 ? ST : LD;
      if (op == ST) wr("rand_wr", ra, 16'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(1, 4));
      else rd("rand_rd", ra, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
